// File: rtl/cmp_share_arb.sv
// ============================================================================
// Module      : cmp_share_arb
// Description : Round-robin arbiter that time-shares one unsigned N-bit
//               comparator between NREQ requesters. One request is granted
//               per cycle and its 1-bit result is returned through a single
//               registered output slot tagged with the requester index.
//               Optional build macro CMP_ARB_SIGNED_EN enables signed
//               opcodes 6 (signed lt) and 7 (signed gte).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// comparator : plain unsigned magnitude comparator shared by all requesters.
// ----------------------------------------------------------------------------
module comparator #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq,
    output logic         lt,
    output logic         gt
);

    assign eq = (a == b);
    assign lt = (a < b);
    assign gt = (a > b);

endmodule

// ----------------------------------------------------------------------------
// cmp_share_arb : arbiter, operand mux, flag select and output slot.
// ----------------------------------------------------------------------------
module cmp_share_arb #(
    parameter  int N    = 8,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_flag,
    output logic [2:0]        rsp_op
);

    localparam logic [2:0] c_OP_EQ  = 3'd0;
    localparam logic [2:0] c_OP_NEQ = 3'd1;
    localparam logic [2:0] c_OP_LT  = 3'd2;
    localparam logic [2:0] c_OP_LTE = 3'd3;
    localparam logic [2:0] c_OP_GT  = 3'd4;
    localparam logic [2:0] c_OP_GTE = 3'd5;
`ifdef CMP_ARB_SIGNED_EN
    localparam logic [2:0] c_OP_SLT  = 3'd6;
    localparam logic [2:0] c_OP_SGTE = 3'd7;
`endif

    // Output slot state: EMPTY means no result is being presented.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;

    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_flag;
    logic [2:0]       r_rsp_op;

    logic             w_can_issue;
    logic             w_gnt_found;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_fire;

    logic [N-1:0]     w_sel_a;
    logic [N-1:0]     w_sel_b;
    logic [2:0]       w_sel_op;
    logic [N-1:0]     w_cmp_a;
    logic [N-1:0]     w_cmp_b;
    logic             w_cmp_eq;
    logic             w_cmp_lt;
    logic             w_cmp_gt;
    logic             w_flag;

    // Index base+off wrapped into 0..NREQ-1 without needing a power of two.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int             off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + (IDW+1)'(off);
        if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
        end
        return sum[IDW-1:0];
    endfunction

    // A new result may be accepted when the slot is empty or being drained;
    // nothing is granted while reset is held so req_ready reads zero then.
    assign w_can_issue = !rst && ((r_state == ST_EMPTY) || rsp_ready);
    assign w_fire      = w_can_issue && w_gnt_found;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_gnt_found && req_valid[wrap_idx(r_ptr, i)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = wrap_idx(r_ptr, i);
            end
        end
    end

    // Drive the one-hot grant back to the winning requester.
    always_comb begin
        req_ready = '0;
        if (w_fire) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Route the granted requester's operands and opcode to the comparator.
    assign w_sel_a  = req_a[w_gnt_idx*N +: N];
    assign w_sel_b  = req_b[w_gnt_idx*N +: N];
    assign w_sel_op = req_op[w_gnt_idx*3 +: 3];

`ifdef CMP_ARB_SIGNED_EN
    // Flipping both sign bits maps two's complement order onto unsigned
    // order, so the same lt output serves the signed opcodes.
    logic w_signed_op;
    assign w_signed_op = (w_sel_op[2:1] == 2'b11);
    assign w_cmp_a     = {w_sel_a[N-1] ^ w_signed_op, w_sel_a[N-2:0]};
    assign w_cmp_b     = {w_sel_b[N-1] ^ w_signed_op, w_sel_b[N-2:0]};
`else
    assign w_cmp_a = w_sel_a;
    assign w_cmp_b = w_sel_b;
`endif

    comparator #(
        .N (N)
    ) u_comparator (
        .a  (w_cmp_a),
        .b  (w_cmp_b),
        .eq (w_cmp_eq),
        .lt (w_cmp_lt),
        .gt (w_cmp_gt)
    );

    // Pick the flag requested by the opcode; unsupported opcodes read zero.
    always_comb begin
        w_flag = 1'b0;
        case (w_sel_op)
            c_OP_EQ:   w_flag = w_cmp_eq;
            c_OP_NEQ:  w_flag = !w_cmp_eq;
            c_OP_LT:   w_flag = w_cmp_lt;
            c_OP_LTE:  w_flag = w_cmp_lt || w_cmp_eq;
            c_OP_GT:   w_flag = w_cmp_gt;
            c_OP_GTE:  w_flag = !w_cmp_lt;
`ifdef CMP_ARB_SIGNED_EN
            c_OP_SLT:  w_flag = w_cmp_lt;
            c_OP_SGTE: w_flag = !w_cmp_lt;
`endif
            default:   w_flag = 1'b0;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Slot next state: fill on grant, drain on accept with no new grant.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_fire) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rsp_ready && !w_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Advance the round-robin pointer past each granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Capture the granted result; contents hold whenever no grant occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_id   <= '0;
            r_rsp_flag <= 1'b0;
            r_rsp_op   <= '0;
        end else if (w_fire) begin
            r_rsp_id   <= w_gnt_idx;
            r_rsp_flag <= w_flag;
            r_rsp_op   <= w_sel_op;
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_flag  = r_rsp_flag;
    assign rsp_op    = r_rsp_op;

endmodule

`default_nettype wire

// File: tb/tb_cmp_share_arb.sv
// ============================================================================
// Module      : tb_cmp_share_arb
// Description : Directed self-checking bench for cmp_share_arb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_share_arb;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

`ifdef CMP_ARB_SIGNED_EN
    localparam logic [7:0] c_EXP_80 = 8'b0111_0010;
    localparam logic [7:0] c_EXP_FF = 8'b1010_1001;
`else
    localparam logic [7:0] c_EXP_80 = 8'b0011_0010;
    localparam logic [7:0] c_EXP_FF = 8'b0010_1001;
`endif

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_flag;
    logic [2:0]        rsp_op;

    int checks;
    int failures;

    cmp_share_arb #(
        .N    (N),
        .NREQ (NREQ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_flag  (rsp_flag),
        .rsp_op    (rsp_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_op[i*3 +: 3] = op;
    endtask

    initial begin
        int g;
        logic [7:0] exp_vec;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        // Reset values, with requests pending to show no grant leaks out.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id",    32'(rsp_id),    32'd0);
        chk("reset_rsp_flag",  32'(rsp_flag),  32'd0);
        chk("reset_rsp_op",    32'(rsp_op),    32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        rst       = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'd0);

        // Single request: requester 2, 5 < 9.
        set_req(2, 8'd5, 8'd9, 3'd2);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        chk("single_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id",    32'(rsp_id),    32'd2);
        chk("single_flag",  32'(rsp_flag),  32'd1);
        chk("single_op",    32'(rsp_op),    32'd2);
        step();
        chk("single_drain", 32'(rsp_valid), 32'd0);

        // All valid: pointer sits at 3 after the single request.
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i), 8'd2, 3'd2);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            g = (3 + k) % 4;
            #1;
            chk("rr_grant", 32'(req_ready), 32'd1 << g);
            step();
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id",    32'(rsp_id),    32'(g));
            chk("rr_flag",  32'(rsp_flag),  (g < 2) ? 32'd1 : 32'd0);
        end

        // Backpressure: slot holds requester 0's result (0 < 2).
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            step();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id",    32'(rsp_id),    32'd0);
            chk("bp_flag",  32'(rsp_flag),  32'd1);
            chk("bp_op",    32'(rsp_op),    32'd2);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'b0010);
        step();
        chk("bp_r1_id",   32'(rsp_id),   32'd1);
        chk("bp_r1_flag", 32'(rsp_flag), 32'd1);
        req_valid = 4'b1000;
        #1;
        chk("bp_r3_grant", 32'(req_ready), 32'b1000);
        step();
        chk("bp_r3_valid", 32'(rsp_valid), 32'd1);
        chk("bp_r3_id",    32'(rsp_id),    32'd3);
        chk("bp_r3_flag",  32'(rsp_flag),  32'd0);
        req_valid = 4'b0000;
        step();
        chk("bp_drain", 32'(rsp_valid), 32'd0);

        // Opcode sweep, a=0x80 b=0x01.
        exp_vec = c_EXP_80;
        for (int op = 0; op < 8; op++) begin
            set_req(0, 8'h80, 8'h01, 3'(op));
            req_valid = 4'b0001;
            #1;
            chk("sw80_grant", 32'(req_ready), 32'b0001);
            step();
            chk("sw80_flag", 32'(rsp_flag), 32'(exp_vec[op]));
            chk("sw80_op",   32'(rsp_op),   32'(op));
        end

        // Opcode sweep, a=b=0xFF.
        exp_vec = c_EXP_FF;
        for (int op = 0; op < 8; op++) begin
            set_req(0, 8'hFF, 8'hFF, 3'(op));
            #1;
            step();
            chk("swff_flag", 32'(rsp_flag), 32'(exp_vec[op]));
            chk("swff_valid", 32'(rsp_valid), 32'd1);
        end
        req_valid = 4'b0000;
        step();
        chk("sw_drain", 32'(rsp_valid), 32'd0);

        // Reset mid-operation. Pointer is 1 here.
        set_req(0, 8'h10, 8'h20, 3'd2);
        set_req(1, 8'h30, 8'h20, 3'd2);
        set_req(2, 8'h01, 8'h02, 3'd2);
        req_valid = 4'b0110;
        rsp_ready = 1'b0;
        #1;
        chk("mr_grant", 32'(req_ready), 32'b0010);
        step();
        chk("mr_full_valid", 32'(rsp_valid), 32'd1);
        chk("mr_full_id",    32'(rsp_id),    32'd1);
        chk("mr_full_flag",  32'(rsp_flag),  32'd0);
        req_valid = 4'b0101;
        #1;
        chk("mr_hold_ready", 32'(req_ready), 32'd0);
        step();
        chk("mr_hold_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mr_rst_ready", 32'(req_ready), 32'd0);
        chk("mr_rst_id",    32'(rsp_id),    32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mr_post_valid", 32'(rsp_valid), 32'd0);
        chk("mr_post_grant", 32'(req_ready), 32'b0001);
        step();
        chk("mr_post_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mr_post_rsp_id",    32'(rsp_id),    32'd0);
        chk("mr_post_rsp_flag",  32'(rsp_flag),  32'd1);
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        step();
        chk("end_drain", 32'(rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cmp_share_arb.md
# cmp_share_arb

Round-robin arbiter and sequencer that shares one `comparator` instance (N-bit, unsigned) between NREQ requesters. Each requester presents an operand pair and an opcode on a valid/ready channel. The block grants one request per cycle, selects the requested flag from the comparator outputs, and returns a registered 1-bit result tagged with the requester index. It sits between ALU issue ports (branch unit, compare instructions, address checks) and the shared compare logic.

## Interface
- `N`, 8, operand width.
- `NREQ`, 4, number of requesters (2..16).
- `IDW`, `$clog2(NREQ)`, width of response id (derived, not overridden).

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero.
- `req_a`  in  NREQ*N  operand A; slice i belongs to requester i.
- `req_b`  in  NREQ*N  operand B; slice i belongs to requester i.
- `req_op`  in  NREQ*3  opcode; slice i belongs to requester i.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `rsp_flag`  out  1  compare result.
- `rsp_op`  out  3  echoed opcode.

## Operation
- Opcodes: 0 eq, 1 neq, 2 lt, 3 lte, 4 gt, 5 gte, 6/7 see Configuration.
- Output slot state machine:
  - States are EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
  - `can_issue` = EMPTY, or FULL with `rsp_ready`=1.
- Arbitration:
  - When `can_issue`=1 and any `req_valid` is set, grant the first valid index at or after `ptr`, searching upward modulo NREQ.
  - The grant is driven on `req_ready` in the same cycle (combinational from `req_valid`, `ptr` and slot state).
  - When `can_issue`=0, `req_ready`=0.
- On a grant handshake (`req_valid[g]` and `req_ready[g]`):
  - Mux slice g to the shared comparator.
  - Register the selected flag, g and the opcode into the output slot.
  - Set `ptr` to (g+1) mod NREQ. `ptr` is unchanged otherwise.
- Slot transitions:
  - EMPTY with grant → FULL.
  - FULL with `rsp_ready` and no grant → EMPTY.
  - FULL with `rsp_ready` and grant → FULL with new contents.
  - FULL with `rsp_ready`=0 → hold all `rsp_*` stable.
- Requester rule: once `req_valid` is asserted, it and the data stay stable until `req_ready`. The bench checks stability; the block does not.
- Comparison is unsigned on N bits. No width extension.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_flag`=0, `rsp_op`=0, `ptr`=0, `req_ready`=0.
- Latency: a result appears on `rsp_*` one cycle after its grant.
- Throughput: one grant per cycle while `rsp_ready` is held high.
- Fairness: a continuously valid requester is granted within NREQ grants.
- Backpressure: with FULL and `rsp_ready`=0, no grants occur and the held result is never lost or duplicated.
- Simultaneous drain and grant in one cycle is legal and causes no bubble.
- `ptr` wrap-around: after granting NREQ-1, `ptr`=0.
- No valid requests: no grant, `ptr` holds, and the slot drains normally.
- Reset mid-operation: any held result is discarded and no `rsp_valid` pulse follows reset. Requesters must re-present.

## Configuration
- `CMP_ARB_SIGNED_EN` defined:
  - Opcode 6 is signed lt and opcode 7 is signed gte, both two's complement on N bits.
  - Implemented by inverting the operand MSBs into the shared comparator's lt/gte paths.
- Not defined:
  - Opcodes 6 and 7 return `rsp_flag`=0.
  - No signed logic is present.
- All timing and handshake behaviour is identical in both builds.

## Test plan
- Single request, N=8: requester 2 sends a=5, b=9, op=2 with `rsp_ready`=1. Grant appears in the same cycle. Next cycle shows `rsp_valid`=1, `rsp_id`=2, `rsp_flag`=1, `rsp_op`=2.
- All four requesters valid continuously with `rsp_ready`=1: grants go 0,1,2,3,0,… with one result per cycle. `rsp_id` follows the same order.
- Backpressure: result held with `rsp_ready`=0 for 5 cycles while requesters 1 and 3 are valid. `req_ready` stays 0 and `rsp_*` stay stable. Releasing `rsp_ready` grants requester 1 in that same cycle.
- Opcode sweep with a=0x80, b=0x01 over ops 0–5: flags are 0,1,0,0,1,1.
  - With `CMP_ARB_SIGNED_EN`: op 6 gives 1 and op 7 gives 0.
  - Without it: ops 6 and 7 both give 0.
- Reset mid-operation: assert `rst` while FULL with `rsp_ready`=0. `rsp_valid` drops immediately and `ptr`=0. After release, the first grant goes to the lowest valid index.
- Equal operands a=b=0xFF, ops 0–5: flags are 1,0,0,1,0,1.
